// File: rtl/conv_par_serializer.sv
// conv_par_serializer: parallel-to-serial converter for the conv tree link.
// Takes one NUM_CH x DATA_W frame through a valid/ready handshake and emits it
// one bit per clock on SERIAL_OUT. An even-parity bit can be appended, and the
// bit order within each channel is selectable. Frames may be sent back-to-back
// with no gap between them.
//
// Handshake: a frame is accepted on a rising CLK edge where PAR_VALID and
// PAR_READY are both high. PAR_IN is sampled only on that edge. PAR_READY
// depends only on state, counter and RESET, never on PAR_VALID. Upstream must
// hold PAR_IN/PAR_VALID stable until the handshake completes.
module conv_par_serializer #(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 8,
  parameter int MSB_FIRST = 1,
  parameter int PARITY_EN = 0
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [NUM_CH*DATA_W-1:0] PAR_IN,
  input  logic                     PAR_VALID,
  output logic                     PAR_READY,
  output logic                     SERIAL_OUT,
  output logic                     SERIAL_VALID,
  output logic                     FRAME_START,
  output logic                     BUSY
);

  localparam int DATA_BITS = NUM_CH * DATA_W;
  localparam int FRAME_W   = DATA_BITS + PARITY_EN;
  localparam int CNT_W     = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FRAME_W-1:0]   sh_q, sh_d;
  logic                 fs_q, fs_d;
  logic [FRAME_W-1:0]   frame_load;
  logic                 accept;

  // Reorder PAR_IN into transmission order. The MSB of the shift register is
  // the bit sent first, so SERIAL_OUT can come straight from that flop.
  always_comb begin
    frame_load = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int j = 0; j < DATA_W; j++) begin
        if (MSB_FIRST != 0) begin
          frame_load[FRAME_W-1-(c*DATA_W+j)] = PAR_IN[c*DATA_W + (DATA_W-1-j)];
        end else begin
          frame_load[FRAME_W-1-(c*DATA_W+j)] = PAR_IN[c*DATA_W + j];
        end
      end
    end
    if (PARITY_EN != 0) begin
      frame_load[0] = ^PAR_IN;
    end
  end

  // Ready while idle, or during the last bit so the next frame follows with no gap.
  assign PAR_READY = !RESET && ((state_q == ST_IDLE) || (cnt_q == LAST_CNT));
  assign accept    = PAR_VALID && PAR_READY;

  // Next-state logic. The shift register is cleared when the block goes idle,
  // so SERIAL_OUT reads 0 whenever SERIAL_VALID is low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    fs_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        sh_d  = '0;
        cnt_d = '0;
        if (accept) begin
          sh_d    = frame_load;
          state_d = ST_SHIFT;
          fs_d    = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt_q != LAST_CNT) begin
          sh_d  = sh_q << 1;
          cnt_d = cnt_q + 1'b1;
        end else if (accept) begin
          sh_d  = frame_load;
          cnt_d = '0;
          fs_d  = 1'b1;
        end else begin
          sh_d    = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sh_d    = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State register. Reset is asynchronous, so an in-flight frame is dropped at once.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      fs_q    <= fs_d;
    end
  end

  assign SERIAL_OUT   = sh_q[FRAME_W-1];
  assign SERIAL_VALID = (state_q == ST_SHIFT);
  assign BUSY         = (state_q == ST_SHIFT);
  assign FRAME_START  = fs_q;

endmodule
